instruction_fetch_unit: RTL
===========================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 Parameter BUF_DEPTH, default 2: fetch buffer entries; power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-005 fetch_en  input  1  high permits new fetches.
REQ-006 imem_addr  output  32  byte address to instruction memory (asynchronous read port).
REQ-007 imem_dout  input  32  instruction word at imem_addr, valid in the same cycle.
REQ-008 redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-009 redirect_pc  input  32  new fetch byte address.
REQ-010 inst_valid  output  1  buffer head holds a valid instruction.
REQ-011 inst_ready  input  1  consumer accepts head when inst_valid is high.
REQ-012 inst  output  32  head instruction word.
REQ-013 inst_pc  output  32  byte address of head instruction.

Function
REQ-014 imem_addr SHALL equal the fetch_pc register combinationally; bits [1:0] of fetch_pc SHALL always be 0.
REQ-015 pop SHALL occur when inst_valid && inst_ready; push SHALL occur when fetch_en && !redirect_valid && (count < BUF_DEPTH || pop).
REQ-016 On push, {fetch_pc, imem_dout} SHALL be written at the buffer tail and fetch_pc SHALL advance by 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-017 Push and pop in the same cycle SHALL both take effect, including at count == BUF_DEPTH; count is unchanged.
REQ-018 When the buffer is full and no pop occurs, fetch_pc SHALL hold and no write SHALL occur.
REQ-019 When fetch_en is low, fetch_pc SHALL hold, no push SHALL occur, and pops SHALL continue.
REQ-020 redirect_valid SHALL take priority over push and pop: buffer flushed (count = 0), fetch_pc <= {redirect_pc[31:2], 2'b00}, and no push that cycle.
REQ-021 An instruction popped in a redirect cycle SHALL be considered consumed; inst_valid SHALL be 0 in the following cycle.
REQ-022 After a redirect, the first instruction from the new address SHALL be pushed in the next cycle with fetch_en high and SHALL appear with inst_valid high one cycle after that.
REQ-023 Push-to-visible latency SHALL be 1 cycle: an entry pushed at edge N SHALL present inst_valid = 1 after edge N.
REQ-024 Entries SHALL leave in push order; head entry, inst and inst_pc SHALL stay stable while inst_valid && !inst_ready.
REQ-025 When inst_valid is 0, inst and inst_pc SHALL be driven to 0.
REQ-026 Read and write pointers SHALL be log2(BUF_DEPTH) bits, wrapping naturally; count SHALL be log2(BUF_DEPTH)+1 bits.

Reset
REQ-027 While reset is 0 at posedge clk: fetch_pc <= RESET_PC with bits [1:0] cleared, pointers and count <= 0, and inst_valid, inst and inst_pc read 0 from the next cycle.
REQ-028 Reset SHALL override redirect, push and pop in the same cycle, and SHALL discard all in-flight entries.
REQ-029 Buffer data storage does not require reset; outputs SHALL be masked by REQ-025.

Structure
REQ-030 Shared package SHALL hold PC_WIDTH = 32, INST_WIDTH = 32, PC_STEP = 4, and the fetch-entry struct {pc, inst}.
REQ-031 The buffer SHALL be a sub-module fetch_fifo (push, pop, flush, full, empty, head) instantiated once; PC logic stays in the top level.

Verification
REQ-032 Reset release, fetch_en = 1, inst_ready = 1, memory word k = 32'h1000_0000 + k -> consumer sees inst_pc 0, 4, 8 with inst 32'h1000_0000, 32'h1000_0001, 32'h1000_0002 on consecutive cycles; first inst_valid is 1 cycle after the first push.
REQ-033 inst_ready = 0 for 6 cycles, BUF_DEPTH = 2 -> count saturates at 2, imem_addr holds at 8, and inst_pc holds at 0; on re-ready, order 0, 4, 8 is preserved with no loss or duplication.
REQ-034 Full buffer with inst_ready = 1 on the same cycle as a push -> count stays 2 and throughput is 1 instruction per cycle.
REQ-035 redirect_valid with redirect_pc = 32'h0000_0103 while the buffer holds 2 entries -> next cycle inst_valid = 0 and imem_addr = 32'h100; the cycle after, inst_pc = 32'h100.
REQ-036 RESET_PC = 32'hFFFF_FFF8, free-running -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-037 reset driven to 0 mid-stream with redirect_valid = 1 -> next cycle inst_valid = 0 and imem_addr = RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared widths, fetch-entry payload and PC alignment helper for the fetch unit.
package instruction_fetch_unit_pkg;

  localparam int unsigned PC_WIDTH   = 32;
  localparam int unsigned INST_WIDTH = 32;
  localparam int unsigned PC_STEP    = 4;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
    return pc & ~(PC_WIDTH'(PC_STEP - 1));
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Fetch buffer: power-of-two circular FIFO of {pc, inst} entries with flush.
module fetch_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally; flush empties the buffer and wins over push/pop.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage is not reset; consumers mask the head while the buffer is empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: sequential PC generation, redirect handling and a
// small in-order buffer between instruction memory and the decode consumer.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned         BUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [INST_WIDTH-1:0] imem_dout,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   inst_pc
);

  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] fetch_pc_next;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  fetch_entry_t        head;
  fetch_entry_t        wr_entry;

  assign inst_valid = !empty;
  assign pop        = inst_valid && inst_ready;
  assign push       = fetch_en && !redirect_valid && (!full || pop);
  assign imem_addr  = fetch_pc;
  assign wr_entry   = '{pc: fetch_pc, inst: imem_dout};

  // Redirect beats sequential advance; a stalled or disabled fetch holds the PC.
  always_comb begin
    fetch_pc_next = fetch_pc;
    if (redirect_valid) begin
      fetch_pc_next = align_pc(redirect_pc);
    end else if (push) begin
      fetch_pc_next = fetch_pc + PC_WIDTH'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= align_pc(RESET_PC);
    end else begin
      fetch_pc <= fetch_pc_next;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wr_data (wr_entry),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  assign inst    = inst_valid ? head.inst : '0;
  assign inst_pc = inst_valid ? head.pc   : '0;

endmodule
